bus_init_sequencer: RTL and testbench
=====================================

Name: bus_init_sequencer

Overview:
Hardware sequencer that brings a video-chip subsystem to a known state without a behavioural testbench.
- Fills video RAM with a parametrised pattern while holding the target in reset.
- Releases the target, then plays a programmable table of register writes, each held for a fixed bus window.
- Sits between the bus mux and the RAM/register ports, in both simulation tops and FPGA bring-up builds.

Parameters:
ADDR_WIDTH, 12, RAM address width
DATA_WIDTH, 12, RAM/register data width
REG_ADDR_WIDTH, 6, target register address width
TBL_DEPTH, 16, register-write table entries (power of two)
HOLD_CYCLES, 8, clocks each fill or register write is held (>=1)
FILL_COUNT, 1000, RAM words filled from address 0 (<=2**ADDR_WIDTH)
FILL_HI, 4'h8, constant OR-ed into data bits [DATA_WIDTH-1:8]
GAP_CYCLES, 8, idle clocks between fill end and reset release

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; honoured only in IDLE or DONE
tbl_we  in  1  table write strobe; ignored while busy
tbl_addr  in  log2(TBL_DEPTH)  table write index
tbl_data  in  REG_ADDR_WIDTH+DATA_WIDTH  {reg_addr, reg_data} entry
tbl_len  in  log2(TBL_DEPTH)+1  entries to play; sampled on start
mem_addr  out  ADDR_WIDTH  RAM address
mem_do  out  DATA_WIDTH  RAM write data
mem_we  out  1  RAM write enable
mem_di  in  DATA_WIDTH  RAM read data, one-clock latency (used only with the optional feature)
reg_addr  out  REG_ADDR_WIDTH  target register address
reg_do  out  DATA_WIDTH  target register write data
reg_cs  out  1  target chip select
reg_we  out  1  target write enable
target_reset  out  1  reset to target, active high
busy  out  1  sequence in progress
done  out  1  sequence complete; sticky until next start or reset
err  out  1  readback mismatch, sticky

Behaviour:
- Reset: state IDLE. All outputs 0 except target_reset=1. Counters cleared. Table contents are not cleared.
- States: IDLE -> FILL -> (VERIFY) -> GAP -> RELEASE -> REGS -> DONE. From DONE, start re-enters FILL.
- Cycle after start: busy=1, done=0, err=0, target_reset=1.
- FILL:
  - Word i is driven for HOLD_CYCLES clocks: mem_addr=i, mem_do={FILL_HI, i[7:0]}, mem_we=1.
  - mem_we stays high across consecutive words.
  - After word FILL_COUNT-1 is held, mem_we=0 and the next state is entered.
  - FILL_COUNT=0 skips FILL.
- GAP: GAP_CYCLES clocks with all bus outputs 0. target_reset stays 1.
- RELEASE: exactly one clock. target_reset=0, reg_cs=0.
- REGS:
  - Entry k (0..tbl_len-1) is driven for HOLD_CYCLES clocks: reg_addr/reg_do from the table, reg_cs=1, reg_we=1.
  - tbl_len=0 goes straight to DONE.
  - tbl_len>TBL_DEPTH is clamped to TBL_DEPTH.
- DONE: busy=0, done=1, reg_cs=reg_we=0, reg_do=0, target_reset=0.
- All outputs are registered; no combinational path from inputs to outputs.
- start while busy is ignored.
- reset mid-sequence: next clock returns to IDLE, target_reset=1, and all strobes drop the same clock.
- tbl_we during IDLE/DONE writes on that edge. tbl_we while busy is dropped, so the table is not corrupted.
- Counters are wide enough that FILL_COUNT=2**ADDR_WIDTH does not wrap early. The last address is 2**ADDR_WIDTH-1.

Optional Feature:
SEQ_READBACK_EN
- Defined:
  - VERIFY state follows FILL.
  - Each address 0..FILL_COUNT-1 is driven with mem_we=0.
  - mem_di is compared one clock later against {FILL_HI, addr[7:0]}.
  - Any mismatch sets err (sticky until next start/reset).
  - The sequence still proceeds to GAP.
  - VERIFY takes FILL_COUNT+1 clocks.
- Undefined: no VERIFY state; err tied 0; mem_di unused.

Test Plan:
1. Reset held 3 clocks, then released -> target_reset=1, busy=0, done=0, mem_we=reg_cs=0.
2. Fill check, with FILL_COUNT=4, HOLD_CYCLES=2, GAP_CYCLES=3, tbl_len=0, start pulsed -> mem_addr sequence 0,0,1,1,2,2,3,3 with mem_do 0x800..0x803. Then 3 idle clocks, 1 RELEASE clock, and done=1 on the following clock.
3. Register table, with FILL_COUNT=0 and entries {0x18,0x004},{0x20,0x00E},{0x21,0x000},{0x11,0x098},{0x16,0x0C8}, tbl_len=5 -> each write is held 8 clocks in order with reg_cs=reg_we=1, target_reset=0 throughout REGS, and done after 40 REGS clocks.
4. Robustness:
   - start and tbl_we pulsed mid-FILL -> sequence unchanged, table entry unchanged.
   - reset asserted mid-REGS -> next clock reg_cs=0, target_reset=1, state IDLE.
5. With SEQ_READBACK_EN and the RAM model, one stuck bit injected at address 2 -> err=1 at DONE. With a clean RAM -> err=0.
6. tbl_len=31 with TBL_DEPTH=16 -> exactly 16 writes played, then DONE; a second start replays the sequence identically.

Source files
------------

// File: rtl/bus_init_sequencer.sv
// Bring-up sequencer: fills video RAM while holding the target in reset, then plays a register
// write table. Define SEQ_READBACK_EN to add a VERIFY pass that reads the fill back into err.
module bus_init_sequencer #(
    parameter int unsigned           ADDR_WIDTH     = 12,
    parameter int unsigned           DATA_WIDTH     = 12,
    parameter int unsigned           REG_ADDR_WIDTH = 6,
    parameter int unsigned           TBL_DEPTH      = 16,
    parameter int unsigned           HOLD_CYCLES    = 8,
    parameter int unsigned           FILL_COUNT     = 1000,
    parameter logic [DATA_WIDTH-9:0] FILL_HI        = 4'h8,
    parameter int unsigned           GAP_CYCLES     = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   tbl_we,
    input  logic [$clog2(TBL_DEPTH)-1:0]           tbl_addr,
    input  logic [REG_ADDR_WIDTH+DATA_WIDTH-1:0]   tbl_data,
    input  logic [$clog2(TBL_DEPTH):0]             tbl_len,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [DATA_WIDTH-1:0]                  mem_do,
    output logic                                   mem_we,
    input  logic [DATA_WIDTH-1:0]                  mem_di,
    output logic [REG_ADDR_WIDTH-1:0]              reg_addr,
    output logic [DATA_WIDTH-1:0]                  reg_do,
    output logic                                   reg_cs,
    output logic                                   reg_we,
    output logic                                   target_reset,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);

    localparam int unsigned TblAw  = $clog2(TBL_DEPTH);
    localparam int unsigned TblW   = REG_ADDR_WIDTH + DATA_WIDTH;
    // One spare bit so FILL_COUNT == 2**ADDR_WIDTH is representable.
    localparam int unsigned IdxW   = ((ADDR_WIDTH > TblAw) ? ADDR_WIDTH : TblAw) + 1;
    localparam int unsigned MaxCnt = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [IdxW-1:0]  FillLast = IdxW'(FILL_COUNT - 1);
    localparam logic [IdxW-1:0]  FillCnt  = IdxW'(FILL_COUNT);
    localparam logic [CntW-1:0]  HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0]  GapLast  = CntW'(GAP_CYCLES - 1);
    localparam logic [TblAw:0]   TblFull  = (TblAw + 1)'(TBL_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StFill, StVerify, StGap, StRelease, StRegs, StDone
    } state_e;

    localparam state_e StPostFill = (GAP_CYCLES > 0) ? StGap : StRelease;
`ifdef SEQ_READBACK_EN
    localparam state_e StAfterFill = StVerify;
`else
    localparam state_e StAfterFill = StPostFill;
`endif
    localparam state_e StAfterStart = (FILL_COUNT > 0) ? StFill : StAfterFill;

    function automatic logic [DATA_WIDTH-1:0] fill_word(input logic [IdxW-1:0] i);
        logic [DATA_WIDTH-1:0] w;
        w = DATA_WIDTH'(i & IdxW'(255));
        w[DATA_WIDTH-1:8] = FILL_HI;
        return w;
    endfunction

    logic [TblW-1:0] tbl_mem [TBL_DEPTH];
    logic [TblW-1:0] tbl_rd;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [TblAw:0]      len_q, len_d;
    logic                err_q, err_d;

    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]     mem_do_q, mem_do_d;
    logic                      mem_we_q, mem_we_d;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0]     reg_do_q, reg_do_d;
    logic                      reg_cs_q, reg_cs_d;
    logic                      reg_we_q, reg_we_d;
    logic                      target_reset_q, target_reset_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic unused_mem_di;
    assign unused_mem_di = ^mem_di;

    // Table is only writable while idle so a running sequence never sees a torn entry.
    always_ff @(posedge clk) begin
        if (tbl_we && !busy_q) begin
            tbl_mem[tbl_addr] <= tbl_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = err_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StAfterStart;
                    cnt_d   = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    len_d   = (tbl_len > TblFull) ? TblFull : tbl_len;
                end
            end
            StFill: begin
                if (cnt_q == HoldLast) begin
                    cnt_d = '0;
                    if (idx_q == FillLast) begin
                        state_d = StAfterFill;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SEQ_READBACK_EN
            StVerify: begin
                // mem_di carries the word addressed on the previous clock.
                if (idx_q != '0 && mem_di != fill_word(idx_q - 1'b1)) begin
                    err_d = 1'b1;
                end
                if (idx_q == FillCnt) begin
                    state_d = StPostFill;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`endif
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                state_d = (len_q == '0) ? StDone : StRegs;
                idx_d   = '0;
                cnt_d   = '0;
            end
            StRegs: begin
                if (cnt_q == HoldLast) begin
                    cnt_d = '0;
                    if (idx_q == IdxW'(len_q) - 1'b1) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        busy_d         = !(state_d inside {StIdle, StDone});
        done_d         = (state_d == StDone);
        target_reset_d = (state_d inside {StIdle, StFill, StVerify, StGap});
        mem_addr_d     = '0;
        mem_do_d       = '0;
        mem_we_d       = 1'b0;
        reg_addr_d     = '0;
        reg_do_d       = '0;
        reg_cs_d       = 1'b0;
        reg_we_d       = 1'b0;
        tbl_rd         = tbl_mem[idx_d[TblAw-1:0]];

        case (state_d)
            StFill: begin
                mem_addr_d = idx_d[ADDR_WIDTH-1:0];
                mem_do_d   = fill_word(idx_d);
                mem_we_d   = 1'b1;
            end
            StVerify: begin
                if (idx_d < FillCnt) mem_addr_d = idx_d[ADDR_WIDTH-1:0];
            end
            StRegs: begin
                {reg_addr_d, reg_do_d} = tbl_rd;
                reg_cs_d = 1'b1;
                reg_we_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            idx_q          <= '0;
            len_q          <= '0;
            err_q          <= 1'b0;
            mem_addr_q     <= '0;
            mem_do_q       <= '0;
            mem_we_q       <= 1'b0;
            reg_addr_q     <= '0;
            reg_do_q       <= '0;
            reg_cs_q       <= 1'b0;
            reg_we_q       <= 1'b0;
            target_reset_q <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            len_q          <= len_d;
            err_q          <= err_d;
            mem_addr_q     <= mem_addr_d;
            mem_do_q       <= mem_do_d;
            mem_we_q       <= mem_we_d;
            reg_addr_q     <= reg_addr_d;
            reg_do_q       <= reg_do_d;
            reg_cs_q       <= reg_cs_d;
            reg_we_q       <= reg_we_d;
            target_reset_q <= target_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_do       = mem_do_q;
    assign mem_we       = mem_we_q;
    assign reg_addr     = reg_addr_q;
    assign reg_do       = reg_do_q;
    assign reg_cs       = reg_cs_q;
    assign reg_we       = reg_we_q;
    assign target_reset = target_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_bus_init_sequencer.sv
// Bench for bus_init_sequencer: two instances (fill-heavy and table-heavy) checked every cycle
// against an expected-trace model built from the sequence rules.
module tb_bus_init_sequencer;

    localparam int DEPTH = 16;
    localparam int FC_A = 4, H_A = 2, G_A = 3;
    localparam int FC_B = 0, H_B = 8, G_B = 3;
`ifdef SEQ_READBACK_EN
    localparam bit Rb = 1'b1;
`else
    localparam bit Rb = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] mem_addr;
        logic [11:0] mem_do;
        logic        mem_we;
        logic [5:0]  reg_addr;
        logic [11:0] reg_do;
        logic        reg_cs;
        logic        reg_we;
        logic        target_reset;
        logic        busy;
        logic        done;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        tbl_we = 1'b0;
    logic [3:0]  tbl_addr = '0;
    logic [17:0] tbl_data = '0;
    logic [4:0]  tbl_len = '0;

    logic [1:0]  a_mem_addr;
    logic [11:0] a_mem_do, a_mem_di, a_reg_do;
    logic [5:0]  a_reg_addr;
    logic        a_mem_we, a_reg_cs, a_reg_we, a_tr, a_busy, a_done, a_err;
    logic [11:0] b_mem_addr, b_mem_do, b_reg_do;
    logic [5:0]  b_reg_addr;
    logic        b_mem_we, b_reg_cs, b_reg_we, b_tr, b_busy, b_done, b_err;

    logic [11:0] ram [4];
    bit          stuck = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    logic [17:0] mtab [DEPTH];
    obs_t        qa[$];
    obs_t        qb[$];
    obs_t        obs_a, obs_b;

    always #5 clk = ~clk;

    bus_init_sequencer #(
        .ADDR_WIDTH(2), .DATA_WIDTH(12), .REG_ADDR_WIDTH(6), .TBL_DEPTH(DEPTH),
        .HOLD_CYCLES(H_A), .FILL_COUNT(FC_A), .FILL_HI(4'h8), .GAP_CYCLES(G_A)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_len(tbl_len), .mem_addr(a_mem_addr), .mem_do(a_mem_do),
        .mem_we(a_mem_we), .mem_di(a_mem_di), .reg_addr(a_reg_addr), .reg_do(a_reg_do),
        .reg_cs(a_reg_cs), .reg_we(a_reg_we), .target_reset(a_tr), .busy(a_busy),
        .done(a_done), .err(a_err)
    );

    bus_init_sequencer #(
        .ADDR_WIDTH(12), .DATA_WIDTH(12), .REG_ADDR_WIDTH(6), .TBL_DEPTH(DEPTH),
        .HOLD_CYCLES(H_B), .FILL_COUNT(FC_B), .FILL_HI(4'h8), .GAP_CYCLES(G_B)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_len(tbl_len), .mem_addr(b_mem_addr), .mem_do(b_mem_do),
        .mem_we(b_mem_we), .mem_di(12'h000), .reg_addr(b_reg_addr), .reg_do(b_reg_do),
        .reg_cs(b_reg_cs), .reg_we(b_reg_we), .target_reset(b_tr), .busy(b_busy),
        .done(b_done), .err(b_err)
    );

    // Synchronous-read RAM for instance A with an optional stuck bit at address 2.
    always @(posedge clk) begin
        if (a_mem_we) ram[a_mem_addr] <= a_mem_do;
        a_mem_di <= ram[a_mem_addr] | ((stuck && a_mem_addr == 2'd2) ? 12'h010 : 12'h000);
    end

    assign obs_a = {10'b0, a_mem_addr, a_mem_do, a_mem_we, a_reg_addr, a_reg_do, a_reg_cs,
                    a_reg_we, a_tr, a_busy, a_done};
    assign obs_b = {b_mem_addr, b_mem_do, b_mem_we, b_reg_addr, b_reg_do, b_reg_cs,
                    b_reg_we, b_tr, b_busy, b_done};

    function automatic obs_t idle_rec();
        obs_t e = '0;
        e.target_reset = 1'b1;
        return e;
    endfunction

    function automatic obs_t done_rec();
        obs_t e = '0;
        e.done = 1'b1;
        return e;
    endfunction

    function automatic void push(input int sel, input obs_t e);
        if (sel == 0) qa.push_back(e);
        else qb.push_back(e);
    endfunction

    // Expected per-cycle outputs from the first clock after start up to (not incl.) DONE.
    function automatic void build(input int sel, input int fc, input int h, input int g,
                                  input int len);
        obs_t e;
        int   n;
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < fc; i++) begin
            for (int c = 0; c < h; c++) begin
                e = '0;
                e.mem_addr = 12'(i);
                e.mem_do = 12'h800 | 12'(i % 256);
                e.mem_we = 1'b1;
                e.target_reset = 1'b1;
                e.busy = 1'b1;
                push(sel, e);
            end
        end
        if (Rb) begin
            for (int i = 0; i <= fc; i++) begin
                e = '0;
                e.mem_addr = (i < fc) ? 12'(i) : 12'h000;
                e.target_reset = 1'b1;
                e.busy = 1'b1;
                push(sel, e);
            end
        end
        for (int c = 0; c < g; c++) begin
            e = '0;
            e.target_reset = 1'b1;
            e.busy = 1'b1;
            push(sel, e);
        end
        e = '0;
        e.busy = 1'b1;
        push(sel, e);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < h; c++) begin
                e = '0;
                {e.reg_addr, e.reg_do} = mtab[k];
                e.reg_cs = 1'b1;
                e.reg_we = 1'b1;
                e.busy = 1'b1;
                push(sel, e);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_tab(input int k, input logic [17:0] d);
        tbl_we = 1'b1;
        tbl_addr = 4'(k);
        tbl_data = d;
        tick();
        tbl_we = 1'b0;
        mtab[k] = d;
    endtask

    task automatic kick(input int len);
        qa.delete();
        qb.delete();
        build(0, FC_A, H_A, G_A, len);
        build(1, FC_B, H_B, G_B, len);
        tbl_len = 5'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Walks both expected traces cycle by cycle; optionally pokes start/tbl_we or stops early.
    task automatic play(input string tag, input int poke_at, input int stop_at);
        obs_t ea, eb;
        int   t = 0;
        while (qa.size() > 0 || qb.size() > 0) begin
            if (t == stop_at) return;
            ea = (qa.size() > 0) ? qa.pop_front() : done_rec();
            eb = (qb.size() > 0) ? qb.pop_front() : done_rec();
            n_checks += 2;
            if (obs_a !== ea) begin
                n_fail++;
                $display("FAIL %s a cycle %0d: got %h expected %h", tag, t, obs_a, ea);
            end
            if (obs_b !== eb) begin
                n_fail++;
                $display("FAIL %s b cycle %0d: got %h expected %h", tag, t, obs_b, eb);
            end
            if (t == poke_at) begin
                start = 1'b1;
                tbl_we = 1'b1;
                tbl_addr = 4'd0;
                tbl_data = 18'($urandom);
            end
            tick();
            start = 1'b0;
            tbl_we = 1'b0;
            t++;
        end
        for (int c = 0; c < 2; c++) begin
            n_checks += 2;
            if (obs_a !== done_rec()) begin
                n_fail++;
                $display("FAIL %s a done: got %h expected %h", tag, obs_a, done_rec());
            end
            if (obs_b !== done_rec()) begin
                n_fail++;
                $display("FAIL %s b done: got %h expected %h", tag, obs_b, done_rec());
            end
            tick();
        end
        n_checks += 2;
        if (a_err !== (Rb && stuck)) begin
            n_fail++;
            $display("FAIL %s a err: got %b expected %b", tag, a_err, Rb && stuck);
        end
        if (b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s b err: got %b expected 0", tag, b_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks += 4;
        if (obs_a !== idle_rec()) begin
            n_fail++;
            $display("FAIL reset a: got %h expected %h", obs_a, idle_rec());
        end
        if (obs_b !== idle_rec()) begin
            n_fail++;
            $display("FAIL reset b: got %h expected %h", obs_b, idle_rec());
        end
        if (a_err !== 1'b0 || b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset err: got %b%b expected 00", a_err, b_err);
        end
        tick();
        if (obs_a !== idle_rec()) begin
            n_fail++;
            $display("FAIL reset hold a: got %h expected %h", obs_a, idle_rec());
        end
    endtask

    task automatic test_fill();
        kick(0);
        play("fill", -1, -1);
    endtask

    task automatic test_regs();
        wr_tab(0, {6'h18, 12'h004});
        wr_tab(1, {6'h20, 12'h00E});
        wr_tab(2, {6'h21, 12'h000});
        wr_tab(3, {6'h11, 12'h098});
        wr_tab(4, {6'h16, 12'h0C8});
        kick(5);
        play("regs", -1, -1);
    endtask

    task automatic test_robust();
        kick(5);
        play("poke_mid_fill", 2, -1);
        kick(5);
        play("pre_reset", -1, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks += 2;
        if (obs_a !== idle_rec()) begin
            n_fail++;
            $display("FAIL mid_reset a: got %h expected %h", obs_a, idle_rec());
        end
        if (obs_b !== idle_rec()) begin
            n_fail++;
            $display("FAIL mid_reset b: got %h expected %h", obs_b, idle_rec());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < DEPTH; k++) wr_tab(k, 18'($urandom));
        kick(31);
        play("clamp", -1, -1);
        kick(31);
        play("replay", -1, -1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 3; w++) wr_tab($urandom_range(0, DEPTH - 1), 18'($urandom));
            kick($urandom_range(0, 31));
            play("random", -1, -1);
        end
    endtask

    task automatic test_readback();
        stuck = 1'b1;
        kick(2);
        play("readback_stuck", -1, -1);
        stuck = 1'b0;
        kick(2);
        play("readback_clean", -1, -1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_regs();
        test_robust();
        test_back_to_back();
        test_random();
        test_readback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
